// File: rtl/asphalt_pio_pkg.sv
// Shared register map and capability word for the asphalt PWM-capable parallel output port.
package asphalt_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_DUTY     = 3'd2;
  localparam logic [2:0] ADDR_PRESC    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_RSVD     = 3'd6;
  localparam logic [2:0] ADDR_CAPS     = 3'd7;

  // CAPS lets software discover the PWM resolution and number of outputs.
  function automatic logic [31:0] caps_word(input int pwm_bits, input int width);
    logic [7:0] p;
    logic [7:0] w;
    p = pwm_bits[7:0];
    w = width[7:0];
    return {16'h0000, p, w};
  endfunction

endpackage

// File: rtl/asphalt_pwm_pio_if.sv
// Avalon-MM slave bus bundle for asphalt_pwm_pio.
interface asphalt_pwm_pio_if;

  // Handshake: a write is accepted at any rising edge where chipselect=1 and
  // write_n=0 (no backpressure); readdata is zero-wait-state, driven
  // combinationally from address at all times.
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/asphalt_pwm_gen.sv
// Prescaled PWM counter producing a single pwm_on level from a duty setting.
module asphalt_pwm_gen #(
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESC_BITS-1:0] presc,
  input  logic [PWM_BITS-1:0]   duty,
  input  logic                  restart,
  output logic                  pwm_on
);

  logic [PRESC_BITS-1:0] presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  tick;

  assign tick = (presc_cnt == presc);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // Full-scale duty means 100% on rather than one short cycle per period.
  always_comb begin
    pwm_on = (duty == {PWM_BITS{1'b1}}) || (pwm_cnt < duty);
  end

endmodule

// File: rtl/asphalt_pwm_pio.sv
// Parallel output port with per-bit static/PWM mode, set/clear aliases and a capability word.
module asphalt_pwm_pio
  import asphalt_pio_pkg::*;
#(
  parameter int WIDTH      = 14,
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  asphalt_pwm_pio_if.slave     bus,
  output logic [WIDTH-1:0]     out_port
);

  localparam logic [31:0] CAPS = caps_word(PWM_BITS, WIDTH);

  logic [WIDTH-1:0]      data;
  logic [WIDTH-1:0]      mode;
  logic [PWM_BITS-1:0]   duty;
  logic [PRESC_BITS-1:0] presc;
  logic                  wr;
  logic                  restart;
  logic                  pwm_on;
  logic                  unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign restart      = wr && (bus.address == ADDR_PRESC);
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= '0;
      mode     <= '0;
      duty     <= '0;
      presc    <= '0;
      out_port <= '0;
    end else begin
      if (wr) begin
        case (bus.address)
          ADDR_DATA:     data  <= bus.writedata[WIDTH-1:0];
          ADDR_MODE:     mode  <= bus.writedata[WIDTH-1:0];
          ADDR_DUTY:     duty  <= bus.writedata[PWM_BITS-1:0];
          ADDR_PRESC:    presc <= bus.writedata[PRESC_BITS-1:0];
          ADDR_OUTSET:   data  <= data | bus.writedata[WIDTH-1:0];
          ADDR_OUTCLEAR: data  <= data & ~bus.writedata[WIDTH-1:0];
          default: ;
        endcase
      end
      // Static bits follow DATA; PWM-mode bits are gated by the shared pwm_on.
      out_port <= data & (~mode | {WIDTH{pwm_on}});
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: bus.readdata = 32'(data);
      ADDR_MODE:  bus.readdata = 32'(mode);
      ADDR_DUTY:  bus.readdata = 32'(duty);
      ADDR_PRESC: bus.readdata = 32'(presc);
      ADDR_CAPS:  bus.readdata = CAPS;
      default:    bus.readdata = '0;
    endcase
  end

  asphalt_pwm_gen #(
    .PWM_BITS   (PWM_BITS),
    .PRESC_BITS (PRESC_BITS)
  ) u_pwm_gen (
    .clk     (clk),
    .reset   (reset),
    .presc   (presc),
    .duty    (duty),
    .restart (restart),
    .pwm_on  (pwm_on)
  );

endmodule

// File: doc/asphalt_pwm_pio.md
ASPHALT_PWM_PIO -- requirements
Module: asphalt_pwm_pio

Interface
REQ-001 Parameter WIDTH, default 14, number of output bits; legal range 1..32.
REQ-002 Parameter PWM_BITS, default 8, PWM counter and duty width; legal range 2..16.
REQ-003 Parameter PRESC_BITS, default 16, prescaler register width; legal range 1..24.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 address  input  3  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select; writes ignored when low.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  zero-wait-state read data, combinational from address.
REQ-011 out_port  output  WIDTH  registered LED drive.

Function
REQ-012 Write occurs when chipselect=1 and write_n=0 at a rising edge; register updates at that edge.
REQ-013 Register map: 0 DATA (rw, WIDTH bits); 1 MODE (rw, WIDTH bits, 1=PWM, 0=static); 2 DUTY (rw, PWM_BITS); 3 PRESC (rw, PRESC_BITS); 4 OUTSET (wo); 5 OUTCLEAR (wo); 6 reserved; 7 CAPS (ro).
REQ-014 OUTSET write: DATA <= DATA | writedata[WIDTH-1:0]; OUTCLEAR write: DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-015 Reads of 4, 5 return current DATA; read of 6 returns 0; read of 7 returns {16'b0, PWM_BITS[7:0], WIDTH[7:0]}.
REQ-016 All read values zero-extended to 32 bits; writedata bits above register width ignored; writes to 6, 7 have no effect.
REQ-017 Prescaler counter presc_cnt counts 0..PRESC; tick asserted for the one cycle where presc_cnt==PRESC, then presc_cnt <= 0.
REQ-018 PRESC=0 gives tick every cycle.
REQ-019 pwm_cnt (PWM_BITS) increments on each tick, wrapping from 2^PWM_BITS-1 to 0.
REQ-020 pwm_on = (pwm_cnt < DUTY), except DUTY = 2^PWM_BITS-1 forces pwm_on=1 (100%); DUTY=0 gives pwm_on=0 always.
REQ-021 A write to PRESC clears presc_cnt and pwm_cnt to 0 at the same edge (phase restart).
REQ-022 A write to DUTY takes effect on pwm_on from the next cycle; counters not disturbed.
REQ-023 out_port[i] <= DATA[i] & (MODE[i] ? pwm_on : 1), registered; out_port reflects a register write one cycle after the write edge.
REQ-024 PWM period = (PRESC+1) * 2^PWM_BITS clock cycles; high time = (PRESC+1) * DUTY cycles.

Reset
REQ-025 While reset=1 at a rising edge: DATA, MODE, DUTY, PRESC, presc_cnt, pwm_cnt, out_port all <= 0.
REQ-026 Reset has priority over a simultaneous bus write; the write is lost.
REQ-027 Reset mid-PWM-period returns counters to 0; first post-reset period is full-length.
REQ-028 readdata after reset: address 0..5 read 0; CAPS unaffected by reset.

Structure
REQ-029 Register address constants (ADDR_DATA..ADDR_CAPS) live in shared package asphalt_pio_pkg.
REQ-030 Prescaler + PWM counter + pwm_on compare is one sub-module, asphalt_pwm_gen (params PWM_BITS, PRESC_BITS; ports clk, reset, presc, duty, restart, pwm_on).
REQ-031 No other sub-modules; no multicycle or combinational loops; readdata mux is the only combinational output.

Verification
REQ-032 Reset, write DATA=0x2A5A, MODE=0 -> out_port=0x2A5A one cycle after write edge; read addr 0 returns 0x00002A5A.
REQ-033 DATA=0x0F0F, write OUTSET=0x3000 then OUTCLEAR=0x000F -> DATA reads 0x3F00; out_port=0x3F00.
REQ-034 DATA=0x0001, MODE=0x0001, PRESC=0, DUTY=64 -> out_port[0] high 64 of every 256 cycles, period 256 exactly.
REQ-035 PRESC=3, DUTY=255 -> out_port[0] constant 1; DUTY=0 -> constant 0 from next cycle.
REQ-036 Mid-period write PRESC=1 -> pwm_cnt and presc_cnt 0 next cycle; new period 512 cycles.
REQ-037 Assert reset during write of DATA=0x3FFF -> DATA and out_port 0; read addr 7 returns 0x0000080E.
